// File: rtl/pong_match_sequencer.sv
// Match-level controller for the ping-pong game: sequences serve/rally/point/over,
// paces the ball with a shrinking step period, keeps scores and rotates the serve.
module pong_match_sequencer #(
  parameter int unsigned CNT_W           = 26,
  parameter int unsigned TICK_DIV_INIT   = 25_000_000,
  parameter int unsigned TICK_DIV_MIN    = 5_000_000,
  parameter int unsigned TICK_DIV_STEP   = 2_500_000,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned WIN_SCORE       = 15,
  parameter int unsigned SERVES_PER_TURN = 2,
  parameter int unsigned PAUSE_CYCLES    = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               serve_go,
  input  logic               hit,
  input  logic               point_p0,
  input  logic               point_p1,
  output logic               step_en,
  output logic               serve_req,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         match_state
);

  localparam int unsigned PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam int unsigned TURN_W  = $clog2(SERVES_PER_TURN + 1);

  localparam logic [CNT_W-1:0]   DivInit   = CNT_W'(TICK_DIV_INIT);
  localparam logic [CNT_W-1:0]   DivMin    = CNT_W'(TICK_DIV_MIN);
  localparam logic [CNT_W-1:0]   DivStep   = CNT_W'(TICK_DIV_STEP);
  localparam logic [CNT_W-1:0]   DivFloor  = CNT_W'(TICK_DIV_MIN + TICK_DIV_STEP);
  localparam logic [PAUSE_W-1:0] PauseLast = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [TURN_W-1:0]  TurnMax   = TURN_W'(SERVES_PER_TURN);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StRally = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               side_q, side_d;
  logic [TURN_W-1:0]  turn_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= DivInit;
      pause_q  <= '0;
      score0_q <= '0;
      score1_q <= '0;
      turn_q   <= '0;
      side_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pause_q  <= pause_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      turn_q   <= turn_d;
      side_q   <= side_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pause_d  = pause_q;
    score0_d = score0_q;
    score1_d = score1_q;
    turn_d   = turn_q;
    side_d   = side_q;
    turn_inc = turn_q + 1'b1;
    step_en  = 1'b0;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d  = StServe;
          score0_d = '0;
          score1_d = '0;
          turn_d   = '0;
          side_d   = 1'b0;
        end
      end
      StServe: begin
        if (serve_go) begin
          state_d  = StRally;
          period_d = DivInit;
          cnt_d    = DivInit - 1'b1;
        end
      end
      StRally: begin
        step_en = (cnt_q == '0);
        // A point outranks a simultaneous hit; player 0 outranks player 1.
        if (point_p0 || point_p1) begin
          if (point_p0) score0_d = score0_q + 1'b1;
          else          score1_d = score1_q + 1'b1;
          if (turn_inc == TurnMax) begin
            turn_d = '0;
            side_d = ~side_q;
          end else begin
            turn_d = turn_inc;
          end
          pause_d = PauseLast;
          state_d = StPoint;
        end else if (hit) begin
          period_d = (period_q >= DivFloor) ? period_q - DivStep : DivMin;
        end
        // A reload coinciding with a hit already uses the shortened period.
        cnt_d = (cnt_q == '0) ? period_d - 1'b1 : cnt_q - 1'b1;
      end
      StPoint: begin
        if (pause_q == '0) begin
          state_d = (score0_q == WinScore || score1_q == WinScore) ? StOver : StServe;
        end else begin
          pause_d = pause_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign serve_req   = (state_q == StServe);
  assign game_over   = (state_q == StOver);
  assign winner      = game_over && (score1_q == WinScore);
  assign serve_side  = side_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign match_state = state_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench: stimulus queues expected state snapshots and step_en cycles,
// monitors pop them whenever the DUT's outputs change or step_en fires.
module tb_pong_match_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, serve_go, hit, point_p0, point_p1;
  logic       step_en, serve_req, serve_side, game_over, winner;
  logic [3:0] score0, score1;
  logic [2:0] match_state;

  pong_match_sequencer #(
    .CNT_W(8), .TICK_DIV_INIT(8), .TICK_DIV_MIN(3), .TICK_DIV_STEP(2),
    .SCORE_W(4), .WIN_SCORE(3), .SERVES_PER_TURN(2), .PAUSE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .serve_go(serve_go), .hit(hit),
    .point_p0(point_p0), .point_p1(point_p1), .step_en(step_en), .serve_req(serve_req),
    .serve_side(serve_side), .score0(score0), .score1(score1), .game_over(game_over),
    .winner(winner), .match_state(match_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       side;
    logic       req;
    logic       go;
    logic       win;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
  } exp_t;

  exp_t  snap_q[$];
  int    step_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  snap_t prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(input logic [2:0] st, input logic [3:0] s0,
                               input logic [3:0] s1, input logic side, input logic win);
    snap_t s;
    s.st = st; s.s0 = s0; s.s1 = s1; s.side = side;
    s.req = (st == 3'd1);
    s.go  = (st == 3'd4);
    s.win = win;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d s0=%0d s1=%0d side=%0d req=%0d over=%0d win=%0d",
                     s.st, s.s0, s.s1, s.side, s.req, s.go, s.win);
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.st = match_state; s.s0 = score0; s.s1 = score1; s.side = serve_side;
    s.req = serve_req; s.go = game_over; s.win = winner;
    return s;
  endfunction

  // Snapshot monitor: every change in the registered outputs must be expected.
  always @(negedge clk) begin
    snap_t cur;
    exp_t  e;
    cur = sample();
    if (cur !== prev) begin
      n_cmp++;
      if (snap_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d: got %s, wanted no change", cyc, fmt(cur));
      end else begin
        e = snap_q.pop_front();
        if (cur !== e.s || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL snapshot: got %s at cyc %0d, want %s at cyc %0d",
                   fmt(cur), cyc, fmt(e.s), e.cyc);
        end
      end
    end
    prev = cur;
  end

  // Step monitor: every step_en pulse must land on an expected cycle.
  always @(negedge clk) begin
    int want;
    if (step_en === 1'b1) begin
      n_cmp++;
      if (step_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step: got step_en at cyc %0d, want none", cyc);
      end else begin
        want = step_q.pop_front();
        if (want != cyc) begin
          n_bad++;
          $display("FAIL step_time: got step_en at cyc %0d, want cyc %0d", cyc, want);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_snap(input snap_t s, input int c);
    exp_t e;
    e.s = s;
    e.cyc = c;
    snap_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    snap_t cur;
    cur = sample();
    n_cmp++;
    if (cur !== '0 || step_en !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got %s step_en=%0d, want all zero", name, fmt(cur), step_en);
    end
  endtask

  // One point from serve: serve_go, point in the 2nd rally cycle, then the pause.
  task automatic play_point(input logic p1, input logic [3:0] b0, input logic [3:0] b1,
                            input logic bs, input logic [3:0] a0, input logic [3:0] a1,
                            input logic as, input logic over, input logic win);
    int t;
    t = cyc;
    push_snap(mk(3'd2, b0, b1, bs, 1'b0), t + 1);
    serve_go = 1'b1; tick(); serve_go = 1'b0;
    tick();
    push_snap(mk(3'd3, a0, a1, as, 1'b0), t + 3);
    if (over) push_snap(mk(3'd4, a0, a1, as, win), t + 7);
    else      push_snap(mk(3'd1, a0, a1, as, 1'b0), t + 7);
    point_p0 = ~p1; point_p1 = p1; tick(); point_p0 = 1'b0; point_p1 = 1'b0;
    wait_to(t + 8);
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; serve_go = 1'b0; hit = 1'b0;
    point_p0 = 1'b0; point_p1 = 1'b0;
    #12;
    check_zero("reset_state");
    #10 reset = 1'b0;
    tick();

    // Events that IDLE must ignore.
    serve_go = 1'b1; hit = 1'b1; point_p0 = 1'b1; tick();
    serve_go = 1'b0; hit = 1'b0; point_p0 = 1'b0; tick();

    t = cyc;
    push_snap(mk(3'd1, 4'd0, 4'd0, 1'b0, 1'b0), t + 1);
    start = 1'b1; tick(); start = 1'b0;

    // Events that SERVE must ignore.
    hit = 1'b1; tick(); hit = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    point_p1 = 1'b1; tick(); point_p1 = 1'b0;

    // Speed-up: hit on every step_en; spacing 8,6,4,3,3.
    t = cyc;
    push_snap(mk(3'd2, 4'd0, 4'd0, 1'b0, 1'b0), t + 1);
    step_q.push_back(t + 8);  step_q.push_back(t + 14); step_q.push_back(t + 18);
    step_q.push_back(t + 21); step_q.push_back(t + 24);
    serve_go = 1'b1; tick(); serve_go = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_to(t + 8);  hit = 1'b1; tick(); hit = 1'b0;
    wait_to(t + 14); hit = 1'b1; tick(); hit = 1'b0;
    wait_to(t + 18); hit = 1'b1; tick(); hit = 1'b0;
    wait_to(t + 21); hit = 1'b1; tick(); hit = 1'b0;
    wait_to(t + 24); hit = 1'b1; tick(); hit = 1'b0;

    // Point for p1: score next edge, 4 pause cycles, back to SERVE.
    push_snap(mk(3'd3, 4'd0, 4'd1, 1'b0, 1'b0), t + 26);
    push_snap(mk(3'd1, 4'd0, 4'd1, 1'b0, 1'b0), t + 30);
    point_p1 = 1'b1; tick(); point_p1 = 1'b0;
    wait_to(t + 31);

    // Simultaneous p0+p1+hit on a step_en cycle; second point toggles the server.
    t = cyc;
    push_snap(mk(3'd2, 4'd0, 4'd1, 1'b0, 1'b0), t + 1);
    step_q.push_back(t + 8); step_q.push_back(t + 14);
    serve_go = 1'b1; tick(); serve_go = 1'b0;
    wait_to(t + 8); hit = 1'b1; tick(); hit = 1'b0;
    wait_to(t + 14);
    push_snap(mk(3'd3, 4'd1, 4'd1, 1'b1, 1'b0), t + 15);
    push_snap(mk(3'd1, 4'd1, 4'd1, 1'b1, 1'b0), t + 19);
    point_p0 = 1'b1; point_p1 = 1'b1; hit = 1'b1; tick();
    point_p0 = 1'b0; point_p1 = 1'b0; hit = 1'b0;
    wait_to(t + 20);

    // Player 0 wins.
    play_point(1'b0, 4'd1, 4'd1, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0);
    play_point(1'b0, 4'd2, 4'd1, 1'b1, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);

    // Events that OVER must ignore.
    hit = 1'b1; tick(); hit = 1'b0;
    point_p0 = 1'b1; tick(); point_p0 = 1'b0;
    point_p1 = 1'b1; tick(); point_p1 = 1'b0;
    serve_go = 1'b1; tick(); serve_go = 1'b0;

    t = cyc;
    push_snap(mk(3'd1, 4'd0, 4'd0, 1'b0, 1'b0), t + 1);
    start = 1'b1; tick(); start = 1'b0;

    // Player 1 wins; serve_side ends at 1 and must clear on restart.
    play_point(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    play_point(1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    play_point(1'b1, 4'd0, 4'd2, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1);

    t = cyc;
    push_snap(mk(3'd1, 4'd0, 4'd0, 1'b0, 1'b0), t + 1);
    start = 1'b1; tick(); start = 1'b0;

    // Asynchronous reset mid-rally, right on a step_en cycle.
    t = cyc;
    push_snap(mk(3'd2, 4'd0, 4'd0, 1'b0, 1'b0), t + 1);
    serve_go = 1'b1; tick(); serve_go = 1'b0;
    wait_to(t + 8);
    n_cmp++;
    if (step_en !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_step: got step_en=%0d, want 1", step_en);
    end
    push_snap(mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0), t + 8);
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();

    n_cmp++;
    if (snap_q.size() != 0) begin
      n_bad++;
      $display("FAIL snap_queue_drain: got %0d pending, want 0", snap_q.size());
    end
    n_cmp++;
    if (step_q.size() != 0) begin
      n_bad++;
      $display("FAIL step_queue_drain: got %0d pending, want 0", step_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
